// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_pkg
//  Brief    : Shared types and constants for the native mem_valid/mem_ready
//             bus responder and its SRAM.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Value returned on mem_rdata for misses and in every non-response cycle.
    localparam logic [DATA_W-1:0] RDATA_MISS = 32'h0;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_be_1rw.sv
`default_nettype none
// ============================================================================
//  Module   : sram_be_1rw
//  Brief    : Synchronous single-port RAM, four byte-enable lanes, one-cycle
//             read latency, read-before-write on a shared access.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_be_1rw
    import mem_bus_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic              clk,
    input  logic              en,
    input  logic [STRB_W-1:0] we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage array plus output register; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (we[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_sram_responder
//  Brief    : Target side of the mem_valid/mem_ready bus. Decodes a word
//             window, serves reads and byte-lane writes from on-chip SRAM,
//             inserts WAIT_STATES wait cycles, and always completes
//             out-of-window accesses with an err_pulse.
//  Options  : define MEM_ROM_LOCK_EN to write-protect the lowest ROM_WORDS
//             words (locked writes are dropped and flagged with err_pulse).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_sram_responder
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter int          ROM_WORDS   = 256
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [STRB_W-1:0] mem_wstrb,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              err_pulse
);

    localparam int         c_idxW       = $clog2(MEM_WORDS);
    localparam logic [3:0] c_waitStates = 4'(WAIT_STATES);

    state_t              r_state;
    state_t              w_nextState;
    logic [c_idxW-1:0]   r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_hit;
    logic                r_err;
    logic [3:0]          r_cnt;

    logic [ADDR_W-1:0]   w_offset;
    logic                w_hit;
    logic [c_idxW-1:0]   w_idx;
    logic                w_isWrite;
    logic                w_locked;
    logic                w_capture;
    logic                w_sramEn;
    logic [STRB_W-1:0]   w_sramWe;
    logic [c_idxW-1:0]   w_sramAddr;
    logic [DATA_W-1:0]   w_sramRdata;
    logic                w_unused;

    // Window decode: unsigned 32-bit offset, so addresses below the base wrap
    // to a huge value and fall out of the window.
    assign w_offset  = {mem_addr[ADDR_W-1:2], 2'b00} - ADDR_BASE;
    assign w_hit     = (w_offset >> 2) < 32'(MEM_WORDS);
    assign w_idx     = w_offset[2 +: c_idxW];
    assign w_isWrite = (mem_wstrb != '0);

`ifdef MEM_ROM_LOCK_EN
    assign w_locked  = w_isWrite && (32'(w_idx) < 32'(ROM_WORDS));
`else
    localparam int c_unusedRomWords = ROM_WORDS;
    assign w_locked  = 1'b0;
`endif

    // Fetch qualifier and byte offset carry no meaning for this target.
    assign w_unused  = ^{mem_instr, w_offset[1:0]};

    assign w_capture = (r_state == ST_IDLE) && mem_valid;

    // The RAM is read once at capture; a committed write happens at the edge
    // that ends the response cycle, so the response shows the pre-write word.
    assign w_sramWe   = (r_state == ST_RESP && !r_err) ? r_wstrb : '0;
    assign w_sramEn   = w_capture || (w_sramWe != '0);
    assign w_sramAddr = w_capture ? w_idx : r_idx;

    sram_be_1rw #(
        .DEPTH (MEM_WORDS),
        .AW    (c_idxW)
    ) u_sram (
        .clk   (clk),
        .en    (w_sramEn),
        .we    (w_sramWe),
        .addr  (w_sramAddr),
        .wdata (r_wdata),
        .rdata (w_sramRdata)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; dropping mem_valid while waiting aborts the access.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mem_valid) begin
                    w_nextState = (c_waitStates != 4'd0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!mem_valid) begin
                    w_nextState = ST_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Request capture and wait-state counter; payload is frozen after IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx   <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 4'd0;
        end else if (w_capture) begin
            r_idx   <= w_idx;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_hit   <= w_hit;
            r_err   <= !w_hit || w_locked;
            r_cnt   <= c_waitStates;
        end else if (r_state == ST_WAIT) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Output decode: everything is quiet outside the single response cycle.
    always_comb begin
        mem_ready = (r_state == ST_RESP);
        err_pulse = (r_state == ST_RESP) && r_err;
        mem_rdata = (r_state == ST_RESP && r_hit) ? w_sramRdata : RDATA_MISS;
    end

endmodule
`default_nettype wire

// File: doc/mem_sram_responder.md
Name: mem_sram_responder

Overview:
Responder (target) side of the native mem_valid/mem_ready bus driven by the CPU bus adapter. It decodes a word-aligned address window and serves reads and byte-lane writes from on-chip SRAM. A wait-state counter lets the bench and SoC emulate slower memories. Out-of-window accesses always complete so the initiator never hangs, and they are flagged with an error pulse.

Parameters:
ADDR_BASE, 32'h0000_0000, byte base address of window; must be aligned to MEM_WORDS*4
MEM_WORDS, 1024, window/SRAM depth in 32-bit words; power of two, 16..65536
WAIT_STATES, 1, extra cycles between capture and mem_ready; 0..15
ROM_WORDS, 256, lower words write-locked when MEM_ROM_LOCK_EN is defined; ignored otherwise

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  initiator request; held with payload until mem_ready
mem_instr  in  1  fetch qualifier; informational only, no effect on behaviour
mem_addr  in  32  byte address; bits [1:0] ignored
mem_wdata  in  32  write data
mem_wstrb  in  4  byte-lane enables; 4'b0000 = read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  32  read data, valid only while mem_ready=1, else 32'h0
err_pulse  out  1  one-cycle pulse coincident with mem_ready on an out-of-window or locked access

Behaviour:
- Clock/reset: single clock clk. resetn is asynchronous, active-low. All flops clear on reset. Outputs reset to mem_ready=0, mem_rdata=0, err_pulse=0, state=IDLE. SRAM contents are not reset.
- Hit: (mem_addr - ADDR_BASE) >> 2 < MEM_WORDS, using 32-bit unsigned arithmetic. Word index = that value truncated to log2(MEM_WORDS) bits.
- FSM states IDLE, WAIT, RESP.
  - IDLE: on mem_valid=1, capture addr/wdata/wstrb/hit, load cnt=WAIT_STATES, issue SRAM read of the captured index. Go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: decrement cnt each cycle; go to RESP when cnt==1.
  - RESP: mem_ready=1 for exactly one cycle; then go to IDLE.
- Latency: if valid is first seen in IDLE at cycle T, mem_ready is high in cycle T+1+WAIT_STATES.
- Throughput: a new request is sampled the cycle after RESP. Back-to-back requests (valid held high with a new address) complete every WAIT_STATES+2 cycles.
- Read: mem_rdata = SRAM word at the captured index when hit, else 32'h0. mem_rdata is forced to 0 in non-RESP cycles.
- Write: when wstrb!=0 and hit, lane i of wdata is written at the clock edge ending the RESP cycle, for each i with wstrb[i]=1. Other lanes are unchanged. mem_rdata in a write's RESP cycle is the pre-write word.
- Miss: the transaction still completes with the same latency. The write is dropped, rdata=0, err_pulse=1 in the RESP cycle.
- Protocol violation: if mem_valid drops in WAIT, abort to IDLE next cycle. No mem_ready, no write, no err_pulse.
- mem_valid deasserting in the RESP cycle itself does not cancel the write.
- Reset mid-transaction: immediate return to IDLE. Any pending write is discarded.
- Payload changes during WAIT are ignored; the captured values are used.

Optional Feature:
MEM_ROM_LOCK_EN.
- Defined: writes (wstrb!=0) whose word index is < ROM_WORDS are discarded and raise err_pulse in the RESP cycle. Reads of that region are unaffected.
- Undefined: the whole window is writable, ROM_WORDS is unused, and no lock logic is generated.

Decomposition:
- Package mem_bus_pkg holds:
  - FSM state enum (IDLE/WAIT/RESP)
  - bus width constants (ADDR_W=32, DATA_W=32, STRB_W=4)
  - RDATA_MISS=32'h0
- One sub-module, sram_be_1rw: synchronous single-port RAM with 4 byte-enable lanes, depth MEM_WORDS, one-cycle read latency.

Test Plan:
- WAIT_STATES=2: write 32'hCAFEBABE at ADDR_BASE+8 with wstrb=4'hF, then read it -> mem_ready exactly 3 cycles after each valid, read returns 32'hCAFEBABE, err_pulse=0.
- Byte lanes: preload 32'h11223344 at +0x10, write wdata=32'hAABBCCDD with wstrb=4'b0100 -> read returns 32'h11BB3344.
- Miss: read at ADDR_BASE+MEM_WORDS*4 -> mem_ready after normal latency, rdata=0, err_pulse=1. A write there leaves SRAM unchanged.
- Back-to-back: WAIT_STATES=0, valid held for 4 reads at +0,+4,+8,+12 -> four mem_ready pulses 2 cycles apart, each with the correct data.
- Abort/reset: WAIT_STATES=3 write, valid drops in WAIT -> no ready, word unchanged. Repeat with resetn pulled low in WAIT -> outputs 0 immediately, word unchanged, next access served normally.
- MEM_ROM_LOCK_EN with ROM_WORDS=256: write at word 10 -> dropped, err_pulse=1. Write at word 300 -> stored, err_pulse=0.
